pwm_multich_gen: RTL and testbench

//  Parametrised multi-channel PWM generator. Successor of the single-channel 11-bit free-running PWM:

---
 rtl/pwm_multich_gen_pkg.sv | 6 +
 rtl/pwm_chan_cmp.sv | 26 ++
 rtl/pwm_multich_gen.sv | 92 +++++++++
 tb/tb_pwm_multich_gen.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_multich_gen_pkg.sv
// pwm_multich_gen_pkg: shared encodings for the multi-channel PWM generator.
package pwm_multich_gen_pkg;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
  localparam logic PWM_MODE_EDGE = 1'b0;
  localparam logic PWM_MODE_CENTER = 1'b1;
endpackage

// File: rtl/pwm_chan_cmp.sv
// pwm_chan_cmp: one PWM channel (active duty register, comparator, output flop).
module pwm_chan_cmp #(
  parameter int WIDTH = 10
) (
  input  logic             Clk_pwm,
  input  logic             Rst_n,
  input  logic             En,
  input  logic             Load,
  input  logic [WIDTH-1:0] DutyIn,
  input  logic [WIDTH-1:0] Cnt,
  output logic             PwmOut
);
  logic [WIDTH-1:0] dutyAct;
  logic [WIDTH-1:0] dutyEff;
  // A duty loaded at the boundary already governs the boundary cycle, so a period never mixes duties.
  assign dutyEff = Load ? DutyIn : dutyAct;
  always_ff @(posedge Clk_pwm or negedge Rst_n) begin
    if (!Rst_n) begin
      dutyAct <= '0;
      PwmOut <= 1'b0;
    end else begin
      if (Load) dutyAct <= DutyIn;
      PwmOut <= En && (Cnt < dutyEff);
    end
  end
endmodule

// File: rtl/pwm_multich_gen.sv
// pwm_multich_gen: NCH-channel PWM from one shared edge/center-aligned counter,
// with period/mode shadows and a double-buffered duty write port.
module pwm_multich_gen
  import pwm_multich_gen_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int NCH = 2
) (
  input  logic                 Clk_pwm,
  input  logic                 Rst_n,
  input  logic                 En,
  input  logic                 Mode,
  input  logic [WIDTH-1:0]     Period,
  input  logic [NCH*WIDTH-1:0] Duty_data,
  input  logic                 Duty_valid,
  output logic                 Duty_ready,
  output logic [NCH-1:0]       PwmSig,
  output logic                 Period_start
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [WIDTH-1:0] cnt, cntNext, perAct, perEff;
  logic [NCH*WIDTH-1:0] dutyPend;
  dir_e dir, dirNext;
  logic modeAct, modeEff, pendFlag, boundary, load, accept;
  always_ff @(posedge Clk_pwm or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt <= '0;
      dir <= DIR_UP;
    end else begin
      cnt <= cntNext;
      dir <= dirNext;
    end
  end
  // Period/mode take effect on the boundary cycle itself so the new period starts immediately.
  always_comb begin
    cntNext = '0;
    dirNext = DIR_UP;
    if (En) begin
      if (modeEff == PWM_MODE_EDGE) begin
        cntNext = (cnt >= perEff) ? '0 : cnt + ONE;
      end else if (dir == DIR_DOWN) begin
        cntNext = cnt - ONE;
        dirNext = (cnt == ONE) ? DIR_UP : DIR_DOWN;
      end else if (cnt < perEff) begin
        cntNext = cnt + ONE;
      end else begin
        cntNext = (perEff == '0) ? '0 : perEff - ONE;
        dirNext = (perEff > ONE) ? DIR_DOWN : DIR_UP;
      end
    end
  end
  always_comb begin
    boundary = En && (cnt == '0) && (dir == DIR_UP);
    perEff = boundary ? Period : perAct;
    modeEff = boundary ? Mode : modeAct;
    load = boundary && pendFlag;
    Duty_ready = !pendFlag;
    accept = Duty_valid && !pendFlag;
  end
  always_ff @(posedge Clk_pwm or negedge Rst_n) begin
    if (!Rst_n) begin
      perAct <= '0;
      modeAct <= PWM_MODE_EDGE;
      dutyPend <= '0;
      pendFlag <= 1'b0;
      Period_start <= 1'b0;
    end else begin
      if (boundary) begin
        perAct <= Period;
        modeAct <= Mode;
      end
      if (accept) begin
        dutyPend <= Duty_data;
        pendFlag <= 1'b1;
      end else if (load) begin
        pendFlag <= 1'b0;
      end
      Period_start <= boundary;
    end
  end
  for (genvar k = 0; k < NCH; k++) begin : g_chan
    pwm_chan_cmp #(.WIDTH(WIDTH)) u_chan (
      .Clk_pwm(Clk_pwm),
      .Rst_n(Rst_n),
      .En(En),
      .Load(load),
      .DutyIn(dutyPend[k*WIDTH +: WIDTH]),
      .Cnt(cnt),
      .PwmOut(PwmSig[k])
    );
  end
endmodule

// File: tb/tb_pwm_multich_gen.sv
// tb_pwm_multich_gen: randomized and directed checks of pwm_multich_gen against a phase-based model.
module tb_pwm_multich_gen;
  localparam int W = 4;
  localparam int N = 2;
  logic Clk_pwm = 1'b0, Rst_n = 1'b0, En = 1'b0, Mode = 1'b0, Duty_valid = 1'b0;
  logic [W-1:0] Period = '0;
  logic [N*W-1:0] Duty_data = '0;
  logic Duty_ready, Period_start;
  logic [N-1:0] PwmSig;
  int vecs = 0, errs = 0;
  int ph, mP, mDuty [N];
  bit mM, mPend, acc;
  logic [N*W-1:0] mPendData;
  logic [N-1:0] expPwm;
  logic expPs;

  pwm_multich_gen #(.WIDTH(W), .NCH(N)) dut (
    .Clk_pwm(Clk_pwm), .Rst_n(Rst_n), .En(En), .Mode(Mode), .Period(Period),
    .Duty_data(Duty_data), .Duty_valid(Duty_valid), .Duty_ready(Duty_ready),
    .PwmSig(PwmSig), .Period_start(Period_start)
  );

  always #5 Clk_pwm = ~Clk_pwm;

  task automatic model_reset();
    ph = 0; mP = 0; mM = 0; mPend = 0; mPendData = '0;
    mDuty = '{default: 0};
    expPwm = '0; expPs = 0;
  endtask

  // Model: ph is the position within the period; cnt follows from ph, mode and period.
  task automatic step();
    bit oldPend;
    int c, len;
    @(posedge Clk_pwm);
    oldPend = mPend;
    acc = 0;
    if (!En) begin
      ph = 0; expPwm = '0; expPs = 0;
    end else begin
      if (ph == 0) begin
        mP = int'(Period); mM = Mode;
        if (mPend) begin
          for (int k = 0; k < N; k++) mDuty[k] = int'(mPendData[k*W +: W]);
          mPend = 0;
        end
      end
      c = mM ? ((ph <= mP) ? ph : 2 * mP - ph) : ph;
      expPs = (ph == 0);
      for (int k = 0; k < N; k++) expPwm[k] = (c < mDuty[k]);
      len = mM ? ((mP == 0) ? 1 : 2 * mP) : mP + 1;
      ph = (ph + 1) % len;
    end
    if (Duty_valid && !oldPend) begin
      mPend = 1; mPendData = Duty_data; acc = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge Clk_pwm);
    #1;
    vecs++;
    if ({PwmSig, Period_start, Duty_ready} !== 4'b0001) begin
      errs++;
      $display("FAIL reset_init: pwm=%b ps=%b rdy=%b want pwm=00 ps=0 rdy=1", PwmSig, Period_start, Duty_ready);
    end
    @(negedge Clk_pwm);
    Rst_n = 1'b1;
    model_reset();
    En = 1; Period = 3; Duty_data = {4'd0, 4'd2}; Duty_valid = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      vecs++;
      if ({PwmSig, Period_start, Duty_ready} !== {expPwm, expPs, !mPend}) begin
        errs++;
        $display("FAIL reset_run %0d: pwm=%b ps=%b rdy=%b want pwm=%b ps=%b rdy=%b", i, PwmSig, Period_start, Duty_ready, expPwm, expPs, !mPend);
      end
    end
    Rst_n = 1'b0;
    #1;
    vecs++;
    if ({PwmSig, Period_start, Duty_ready} !== 4'b0001) begin
      errs++;
      $display("FAIL reset_async: pwm=%b ps=%b rdy=%b want pwm=00 ps=0 rdy=1", PwmSig, Period_start, Duty_ready);
    end
    Duty_valid = 0; En = 0;
    repeat (2) @(posedge Clk_pwm);
    @(negedge Clk_pwm);
    Rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_edge();
    int hi = 0, lastPs = -1;
    Mode = 0; Period = 9; Duty_data = {4'd0, 4'd3}; Duty_valid = 1;
    step();
    Duty_valid = 0; En = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      vecs++;
      if ({PwmSig, Period_start, Duty_ready} !== {expPwm, expPs, !mPend}) begin
        errs++;
        $display("FAIL edge %0d: pwm=%b ps=%b rdy=%b want pwm=%b ps=%b rdy=%b", i, PwmSig, Period_start, Duty_ready, expPwm, expPs, !mPend);
      end
      if (Period_start) begin
        if (lastPs >= 0) begin
          vecs++;
          if (i - lastPs != 10 || hi != 3) begin
            errs++;
            $display("FAIL edge_window: spacing=%0d highs=%0d want spacing=10 highs=3", i - lastPs, hi);
          end
        end
        lastPs = i; hi = 0;
      end
      hi += int'(PwmSig[0]);
    end
  endtask

  task automatic test_shadow();
    int hi = 0;
    bit seen = 0;
    for (int i = 0; i < 20 && ph != 4; i++) step();
    Duty_data = {4'd0, 4'd5}; Duty_valid = 1;
    step();
    vecs++;
    if (Duty_ready !== 1'b0) begin
      errs++;
      $display("FAIL shadow_ready_low: rdy=%b want 0", Duty_ready);
    end
    Duty_data = {4'd0, 4'd7};
    for (int i = 0; i < 3; i++) begin
      step();
      vecs++;
      if ({PwmSig, Period_start, Duty_ready} !== {expPwm, expPs, !mPend} || acc) begin
        errs++;
        $display("FAIL shadow_blocked %0d: pwm=%b ps=%b rdy=%b want pwm=%b ps=%b rdy=%b", i, PwmSig, Period_start, Duty_ready, expPwm, expPs, !mPend);
      end
    end
    Duty_valid = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      vecs++;
      if ({PwmSig, Period_start, Duty_ready} !== {expPwm, expPs, !mPend}) begin
        errs++;
        $display("FAIL shadow_wait %0d: pwm=%b ps=%b rdy=%b want pwm=%b ps=%b rdy=%b", i, PwmSig, Period_start, Duty_ready, expPwm, expPs, !mPend);
      end
      seen = Period_start;
    end
    vecs++;
    if (!seen || Duty_ready !== 1'b1) begin
      errs++;
      $display("FAIL shadow_boundary: seen=%0d rdy=%b want seen=1 rdy=1", seen, Duty_ready);
    end
    hi = int'(PwmSig[0]);
    for (int i = 0; i < 9; i++) begin
      step();
      hi += int'(PwmSig[0]);
    end
    vecs++;
    if (hi != 5) begin
      errs++;
      $display("FAIL shadow_duty: highs=%0d want 5", hi);
    end
  endtask

  task automatic test_saturation();
    logic [N*W-1:0] duties [3] = '{{4'd0, 4'd10}, {4'd0, 4'd15}, {4'd0, 4'd1}};
    int ok;
    for (int d = 0; d < 3; d++) begin
      if (d == 2) Period = 0;
      Duty_data = duties[d]; Duty_valid = 1;
      ok = 0;
      for (int i = 0; i < 25; i++) begin
        step();
        if (acc) Duty_valid = 0;
        vecs++;
        if ({PwmSig, Period_start, Duty_ready} !== {expPwm, expPs, !mPend}) begin
          errs++;
          $display("FAIL sat%0d %0d: pwm=%b ps=%b rdy=%b want pwm=%b ps=%b rdy=%b", d, i, PwmSig, Period_start, Duty_ready, expPwm, expPs, !mPend);
        end
        if (i >= 15) ok += int'(PwmSig[0]) + ((d == 2) ? int'(Period_start) : 1);
      end
      vecs++;
      if (ok != 20) begin
        errs++;
        $display("FAIL sat_const%0d: score=%0d want 20", d, ok);
      end
    end
  endtask

  task automatic test_center();
    int hi = 0, lastPs = -1;
    Mode = 1; Period = 4; Duty_data = {4'd0, 4'd2}; Duty_valid = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (acc) Duty_valid = 0;
      vecs++;
      if ({PwmSig, Period_start, Duty_ready} !== {expPwm, expPs, !mPend}) begin
        errs++;
        $display("FAIL center %0d: pwm=%b ps=%b rdy=%b want pwm=%b ps=%b rdy=%b", i, PwmSig, Period_start, Duty_ready, expPwm, expPs, !mPend);
      end
      if (Period_start) begin
        if (lastPs >= 16) begin
          vecs++;
          if (i - lastPs != 8 || hi != 3) begin
            errs++;
            $display("FAIL center_window: spacing=%0d highs=%0d want spacing=8 highs=3", i - lastPs, hi);
          end
        end
        lastPs = i; hi = 0;
      end
      hi += int'(PwmSig[0]);
    end
  endtask

  task automatic test_en();
    int lastPs = -1;
    bit found = 0;
    Mode = 0; Period = 9; Duty_data = {4'd0, 4'd3}; Duty_valid = 1;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (acc) Duty_valid = 0;
      found = (mM == 0) && (ph == 5) && !mPend;
    end
    vecs++;
    if (!found || PwmSig[0] !== 1'b0 && expPwm[0] !== 1'b0) begin
      errs++;
      $display("FAIL en_setup: found=%0d pwm=%b want found=1", found, PwmSig);
    end
    Duty_data = {4'd0, 4'd8};
    Duty_valid = 1;
    step();
    Duty_valid = 0;
    En = 0;
    step();
    vecs++;
    if (PwmSig !== 2'b00 || Period_start !== 1'b0) begin
      errs++;
      $display("FAIL en_low: pwm=%b ps=%b want pwm=00 ps=0", PwmSig, Period_start);
    end
    Period = 6;
    repeat (3) step();
    En = 1;
    for (int i = 0; i < 22; i++) begin
      step();
      vecs++;
      if ({PwmSig, Period_start, Duty_ready} !== {expPwm, expPs, !mPend} || (i == 0 && Period_start !== 1'b1)) begin
        errs++;
        $display("FAIL en_resume %0d: pwm=%b ps=%b rdy=%b want pwm=%b ps=%b rdy=%b", i, PwmSig, Period_start, Duty_ready, expPwm, expPs, !mPend);
      end
      if (Period_start) begin
        if (lastPs >= 0) begin
          vecs++;
          if (i - lastPs != 7) begin
            errs++;
            $display("FAIL en_period: spacing=%0d want 7", i - lastPs);
          end
        end
        lastPs = i;
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 40) == 0) En = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) Mode = 1'($urandom);
      if ($urandom_range(0, 15) == 0) Period = W'($urandom);
      Duty_valid = 1'($urandom);
      Duty_data = (N * W)'($urandom);
      step();
      vecs++;
      if ({PwmSig, Period_start, Duty_ready} !== {expPwm, expPs, !mPend}) begin
        errs++;
        $display("FAIL random %0d: pwm=%b ps=%b rdy=%b want pwm=%b ps=%b rdy=%b", i, PwmSig, Period_start, Duty_ready, expPwm, expPs, !mPend);
      end
    end
    Duty_valid = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_edge();
    test_shadow();
    test_saturation();
    test_center();
    test_en();
    En = 1;
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
